// File: rtl/mac_seq_pkg.sv
// Shared types and defaults for the spike-MAC timestep sequencer.
package mac_seq_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam logic [ADDR_W_DEF-1:0] IDLE_ADDR_DEF = 12'hFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ACCUM,
        ST_DRAIN,
        ST_CLEAR
    } seq_state_t;

endpackage

// File: rtl/spike_fifo.sv
// Synchronous spike-address FIFO with flush, registered occupancy and
// first-word-fall-through head output.
module spike_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/mac_step_sequencer.sv
// Spike-MAC timestep sequencer: init pulse, spike FIFO replay, end-of-step clear.
// Optional macro MAC_SEQ_SPIKE_COUNT_EN adds the step_spike_count output.
module mac_step_sequencer
    import mac_seq_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter int                FIFO_DEPTH   = 8,
    parameter int                INIT_CYCLES  = 2,
    parameter int                CLEAR_CYCLES = 2,
    parameter logic [ADDR_W-1:0] IDLE_ADDR    = ADDR_W'(IDLE_ADDR_DEF)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          init_req,
    input  logic                          step_start,
    input  logic                          step_end,
    input  logic                          spike_valid,
    output logic                          spike_ready,
    input  logic [ADDR_W-1:0]             spike_addr,
    output logic                          set_mac,
    output logic                          clear_mac,
    output logic [ADDR_W-1:0]             source_address,
    output logic                          initialized,
    output logic                          busy,
    output logic                          step_done,
    output logic                          cmd_err,
`ifdef MAC_SEQ_SPIKE_COUNT_EN
    output logic [15:0]                   step_spike_count,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int MAX_PULSE = (INIT_CYCLES > CLEAR_CYCLES) ? INIT_CYCLES : CLEAR_CYCLES;
    localparam int CNT_W = $clog2(MAX_PULSE + 1);
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);

    seq_state_t        state;
    logic [CNT_W-1:0]  pulse_cnt;
    logic [LVL_W-1:0]  drain_rem;
    logic [LVL_W-1:0]  level_next;
    logic [ADDR_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              flush;
    logic              accum_entry;
    logic              cmd_ignored;

    assign push        = spike_valid && spike_ready && !fifo_full;
    assign pop         = (state == ST_ACCUM && !fifo_empty) ||
                         (state == ST_DRAIN && drain_rem != '0);
    assign flush       = (state == ST_IDLE) && init_req;
    assign accum_entry = (state == ST_IDLE) && !init_req && step_start && initialized;
    assign level_next  = flush ? '0 : fifo_level + LVL_W'(push) - LVL_W'(pop);

    assign cmd_ignored = ((state != ST_IDLE) && (init_req || step_start)) ||
                         ((state == ST_IDLE) && step_start && (init_req || !initialized)) ||
                         (step_end && (state != ST_ACCUM));

    spike_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (spike_addr),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // spike_ready tracks the occupancy after this edge, so a pop never frees
    // a slot for a push in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            pulse_cnt      <= '0;
            drain_rem      <= '0;
            set_mac        <= 1'b0;
            clear_mac      <= 1'b0;
            source_address <= IDLE_ADDR;
            initialized    <= 1'b0;
            busy           <= 1'b0;
            step_done      <= 1'b0;
            cmd_err        <= 1'b0;
            spike_ready    <= 1'b0;
        end else begin
            step_done      <= 1'b0;
            source_address <= pop ? fifo_head : IDLE_ADDR;
            spike_ready    <= (level_next < LVL_W'(FIFO_DEPTH));
            if (cmd_ignored) begin
                cmd_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (init_req) begin
                        state       <= ST_INIT;
                        set_mac     <= 1'b1;
                        pulse_cnt   <= '0;
                        busy        <= 1'b1;
                        spike_ready <= 1'b0;
                    end else if (accum_entry) begin
                        state <= ST_ACCUM;
                        busy  <= 1'b1;
                    end
                end
                ST_INIT: begin
                    if (pulse_cnt == INIT_LAST) begin
                        state       <= ST_IDLE;
                        set_mac     <= 1'b0;
                        initialized <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        pulse_cnt   <= pulse_cnt + 1'b1;
                        spike_ready <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (step_end) begin
                        state     <= ST_DRAIN;
                        drain_rem <= level_next;
                    end
                end
                // Only entries present at DRAIN entry are replayed this step.
                ST_DRAIN: begin
                    if (drain_rem == '0) begin
                        state     <= ST_CLEAR;
                        clear_mac <= 1'b1;
                        pulse_cnt <= '0;
                    end else begin
                        drain_rem <= drain_rem - 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (pulse_cnt == CLEAR_LAST) begin
                        state     <= ST_IDLE;
                        clear_mac <= 1'b0;
                        busy      <= 1'b0;
                        step_done <= 1'b1;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MAC_SEQ_SPIKE_COUNT_EN
    // Pops only happen in ACCUM/DRAIN, so the count holds from step_done
    // until the next timestep opens.
    always_ff @(posedge clock) begin
        if (reset || accum_entry) begin
            step_spike_count <= '0;
        end else if (pop && step_spike_count != 16'hFFFF) begin
            step_spike_count <= step_spike_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_step_sequencer.sv
// Self-checking bench for mac_step_sequencer: directed scenarios plus a
// randomized run against a queue-based behavioural model.
module tb_mac_step_sequencer;

    localparam int          ADDR_W       = 12;
    localparam int          FIFO_DEPTH   = 8;
    localparam int          INIT_CYCLES  = 2;
    localparam int          CLEAR_CYCLES = 2;
    localparam logic [11:0] IDLE         = 12'hFFF;
    localparam int P_IDLE = 0, P_INIT = 1, P_ACCUM = 2, P_DRAIN = 3, P_CLEAR = 4;

    logic              clock;
    logic              reset;
    logic              init_req;
    logic              step_start;
    logic              step_end;
    logic              spike_valid;
    logic              spike_ready;
    logic [ADDR_W-1:0] spike_addr;
    logic              set_mac;
    logic              clear_mac;
    logic [ADDR_W-1:0] source_address;
    logic              initialized;
    logic              busy;
    logic              step_done;
    logic              cmd_err;
    logic [3:0]        fifo_level;
`ifdef MAC_SEQ_SPIKE_COUNT_EN
    logic [15:0]       step_spike_count;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [11:0] m_q[$];
    int          m_phase;
    int          m_left;
    int          m_drain_left;
    int          m_cnt;
    logic [11:0] m_src;
    logic        m_ready, m_init, m_err, m_done;

    mac_step_sequencer #(
        .ADDR_W       (ADDR_W),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .INIT_CYCLES  (INIT_CYCLES),
        .CLEAR_CYCLES (CLEAR_CYCLES),
        .IDLE_ADDR    (IDLE)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .init_req         (init_req),
        .step_start       (step_start),
        .step_end         (step_end),
        .spike_valid      (spike_valid),
        .spike_ready      (spike_ready),
        .spike_addr       (spike_addr),
        .set_mac          (set_mac),
        .clear_mac        (clear_mac),
        .source_address   (source_address),
        .initialized      (initialized),
        .busy             (busy),
        .step_done        (step_done),
        .cmd_err          (cmd_err),
`ifdef MAC_SEQ_SPIKE_COUNT_EN
        .step_spike_count (step_spike_count),
`endif
        .fifo_level       (fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Spec-level model: advance one cycle using the inputs currently applied.
    task automatic model_update();
        bit push, pop;
        int nphase;
        if (reset) begin
            m_q.delete();
            m_phase = P_IDLE; m_left = 0; m_drain_left = 0; m_cnt = 0;
            m_src = IDLE; m_ready = 0; m_init = 0; m_err = 0; m_done = 0;
            return;
        end
        push = spike_valid && m_ready;
        pop  = (m_phase == P_ACCUM && m_q.size() > 0) || (m_phase == P_DRAIN && m_drain_left > 0);
        if (m_phase != P_IDLE && (init_req || step_start)) m_err = 1;
        if (step_end && m_phase != P_ACCUM) m_err = 1;
        if (m_phase == P_IDLE && step_start && (init_req || !m_init)) m_err = 1;
        m_src = IDLE;
        if (pop) begin
            m_src = m_q.pop_front();
            if (m_cnt < 65535) m_cnt++;
        end
        if (push) m_q.push_back(spike_addr);
        m_done = 0;
        nphase = m_phase;
        case (m_phase)
            P_IDLE: begin
                if (init_req) begin
                    nphase = P_INIT; m_left = INIT_CYCLES; m_q.delete();
                end else if (step_start && m_init) begin
                    nphase = P_ACCUM; m_cnt = 0;
                end
            end
            P_INIT: begin
                m_left--;
                if (m_left == 0) begin nphase = P_IDLE; m_init = 1; end
            end
            P_ACCUM: if (step_end) begin nphase = P_DRAIN; m_drain_left = m_q.size(); end
            P_DRAIN: begin
                if (m_drain_left == 0) begin nphase = P_CLEAR; m_left = CLEAR_CYCLES; end
                else m_drain_left--;
            end
            P_CLEAR: begin
                m_left--;
                if (m_left == 0) begin nphase = P_IDLE; m_done = 1; end
            end
            default: nphase = P_IDLE;
        endcase
        m_phase = nphase;
        m_ready = (m_q.size() < FIFO_DEPTH) && (m_phase != P_INIT);
    endtask

    task automatic cycle();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        init_req = 0; step_start = 0; step_end = 0; spike_valid = 0; spike_addr = '0;
        reset = 1;
        cycle();
        cycle();
        reset = 0;
    endtask

    task automatic do_init();
        init_req = 1;
        cycle();
        init_req = 0;
        repeat (INIT_CYCLES) cycle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({set_mac, clear_mac, initialized, busy, step_done, cmd_err, spike_ready} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000000",
                     {set_mac, clear_mac, initialized, busy, step_done, cmd_err, spike_ready});
        end
        checks++;
        if (source_address !== IDLE) begin
            errors++; $display("[TB] FAIL reset_src: got %h expected %h", source_address, IDLE);
        end
        checks++;
        if (fifo_level !== 4'd0) begin
            errors++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level);
        end
`ifdef MAC_SEQ_SPIKE_COUNT_EN
        checks++;
        if (step_spike_count !== 16'd0) begin
            errors++; $display("[TB] FAIL reset_count: got %0d expected 0", step_spike_count);
        end
`endif
        cycle();
        checks++;
        if (spike_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL post_reset_ready: got ready=%b busy=%b expected ready=1 busy=0", spike_ready, busy);
        end
    endtask

    task automatic test_init();
        do_reset();
        step_start = 1;
        cycle();
        step_start = 0;
        checks++;
        if (cmd_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL start_before_init: got err=%b busy=%b expected err=1 busy=0", cmd_err, busy);
        end
        cycle();
        cycle();
        init_req = 1;
        cycle();
        init_req = 0;
        checks++;
        if ({set_mac, busy, spike_ready, initialized} !== 4'b1100 || source_address !== IDLE) begin
            errors++; $display("[TB] FAIL init_c4: got set,busy,ready,init=%b src=%h expected 1100 src=fff",
                               {set_mac, busy, spike_ready, initialized}, source_address);
        end
        cycle();
        checks++;
        if (set_mac !== 1'b1 || spike_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL init_c5: got set=%b ready=%b expected set=1 ready=0", set_mac, spike_ready);
        end
        cycle();
        checks++;
        if ({set_mac, busy, initialized, spike_ready} !== 4'b0011) begin
            errors++; $display("[TB] FAIL init_c6: got set,busy,init,ready=%b expected 0011",
                               {set_mac, busy, initialized, spike_ready});
        end
    endtask

    task automatic test_cmd_err();
        do_reset();
        do_init();
        checks++;
        if (cmd_err !== 1'b0) begin
            errors++; $display("[TB] FAIL err_clean: got %b expected 0", cmd_err);
        end
        step_end = 1;
        cycle();
        step_end = 0;
        checks++;
        if (cmd_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL err_end_idle: got err=%b busy=%b expected err=1 busy=0", cmd_err, busy);
        end
        step_start = 1;
        cycle();
        step_start = 0;
        init_req = 1;
        cycle();
        init_req = 0;
        checks++;
        if (busy !== 1'b1 || set_mac !== 1'b0) begin
            errors++; $display("[TB] FAIL init_while_busy: got busy=%b set=%b expected busy=1 set=0", busy, set_mac);
        end
        step_end = 1;
        cycle();
        step_end = 0;
        for (int n = 0; n < 20 && step_done !== 1'b1; n++) cycle();
        checks++;
        if (step_done !== 1'b1) begin
            errors++; $display("[TB] FAIL err_step_done: got %b expected 1", step_done);
        end
    endtask

    task automatic test_accum_order();
        logic [11:0] exp_src[5] = '{12'hFFF, 12'd13, 12'd14, 12'd17, 12'hFFF};
        logic [11:0] addrs[3] = '{12'd13, 12'd14, 12'd17};
        step_start = 1;
        cycle();
        step_start = 0;
        for (int i = 0; i < 5; i++) begin
            spike_valid = (i < 3);
            spike_addr  = (i < 3) ? addrs[i] : 12'd0;
            cycle();
            checks++;
            if (source_address !== exp_src[i]) begin
                errors++; $display("[TB] FAIL accum_order[%0d]: got %h expected %h", i, source_address, exp_src[i]);
            end
        end
        spike_valid = 0;
        step_end = 1;
        cycle();
        step_end = 0;
        for (int n = 0; n < 20 && step_done !== 1'b1; n++) cycle();
        checks++;
        if (step_done !== 1'b1) begin
            errors++; $display("[TB] FAIL accum_step_done: got %b expected 1", step_done);
        end
    endtask

    task automatic test_full_drain();
        logic [11:0] exp_q[$];
        logic [11:0] got_q[$];
        int n, clears;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            spike_valid = 1;
            spike_addr  = 12'($urandom_range(0, 12'hFFE));
            exp_q.push_back(spike_addr);
            cycle();
        end
        checks++;
        if (fifo_level !== 4'd8 || spike_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL full_level: got level=%0d ready=%b expected 8 ready=0", fifo_level, spike_ready);
        end
        spike_addr = 12'h123;
        cycle();
        spike_valid = 0;
        checks++;
        if (fifo_level !== 4'd8) begin
            errors++; $display("[TB] FAIL full_saturate: got %0d expected 8", fifo_level);
        end
        step_start = 1;
        cycle();
        step_start = 0;
        step_end = 1;
        cycle();
        step_end = 0;
        n = 1;
        clears = 0;
        if (source_address !== IDLE) got_q.push_back(source_address);
        while (step_done !== 1'b1 && n < 40) begin
            cycle();
            n++;
            if (clear_mac === 1'b1) clears++;
            if (source_address !== IDLE) got_q.push_back(source_address);
            checks++;
            if (clear_mac === 1'b1 && (source_address !== IDLE || set_mac !== 1'b0)) begin
                errors++; $display("[TB] FAIL clear_quiet: got src=%h set=%b expected src=fff set=0", source_address, set_mac);
            end
        end
        checks++;
        if (n !== 11) begin
            errors++; $display("[TB] FAIL end_to_done: got %0d cycles expected 11", n);
        end
        checks++;
        if (clears !== CLEAR_CYCLES) begin
            errors++; $display("[TB] FAIL clear_width: got %0d expected %0d", clears, CLEAR_CYCLES);
        end
        checks++;
        if (got_q !== exp_q) begin
            errors++; $display("[TB] FAIL drain_addrs: got %0d addrs expected %0d in push order", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_clear_push();
        int n;
        step_start = 1;
        cycle();
        step_start = 0;
        step_end = 1;
        cycle();
        step_end = 0;
        for (n = 0; n < 20 && clear_mac !== 1'b1; n++) cycle();
        checks++;
        if (clear_mac !== 1'b1 || spike_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reach_clear: got clear=%b ready=%b expected 1 1", clear_mac, spike_ready);
        end
        spike_valid = 1;
        spike_addr  = 12'd15;
        cycle();
        spike_valid = 0;
        for (n = 0; n < 20 && step_done !== 1'b1; n++) cycle();
        checks++;
        if (step_done !== 1'b1 || fifo_level !== 4'd1) begin
            errors++; $display("[TB] FAIL clear_push_held: got done=%b level=%0d expected done=1 level=1", step_done, fifo_level);
        end
        step_start = 1;
        cycle();
        step_start = 0;
        checks++;
        if (source_address !== IDLE) begin
            errors++; $display("[TB] FAIL accum_entry_src: got %h expected fff", source_address);
        end
        cycle();
        checks++;
        if (source_address !== 12'd15 || fifo_level !== 4'd0) begin
            errors++; $display("[TB] FAIL held_spike_out: got src=%h level=%0d expected 00f level=0", source_address, fifo_level);
        end
        step_end = 1;
        cycle();
        step_end = 0;
        for (n = 0; n < 20 && step_done !== 1'b1; n++) cycle();
    endtask

`ifdef MAC_SEQ_SPIKE_COUNT_EN
    task automatic test_spike_count();
        step_start = 1;
        cycle();
        step_start = 0;
        for (int i = 0; i < 5; i++) begin
            spike_valid = 1;
            spike_addr  = 12'($urandom_range(0, 12'hFFE));
            cycle();
        end
        spike_valid = 0;
        step_end = 1;
        cycle();
        step_end = 0;
        for (int n = 0; n < 30 && step_done !== 1'b1; n++) cycle();
        checks++;
        if (step_done !== 1'b1 || step_spike_count !== 16'd5) begin
            errors++; $display("[TB] FAIL spike_count: got done=%b count=%0d expected done=1 count=5", step_done, step_spike_count);
        end
    endtask
`endif

    task automatic test_reset_drain();
        for (int i = 0; i < 5; i++) begin
            spike_valid = 1;
            spike_addr  = 12'(100 + i);
            cycle();
        end
        spike_valid = 0;
        step_start = 1;
        cycle();
        step_start = 0;
        step_end = 1;
        cycle();
        step_end = 0;
        checks++;
        if (fifo_level !== 4'd4 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL drain_setup: got level=%0d busy=%b expected 4 1", fifo_level, busy);
        end
        reset = 1;
        cycle();
        checks++;
        if ({set_mac, clear_mac, initialized, busy, step_done, cmd_err, spike_ready} !== 7'b0 ||
            source_address !== IDLE || fifo_level !== 4'd0) begin
            errors++; $display("[TB] FAIL reset_in_drain: got flags=%b src=%h level=%0d expected 0000000 fff 0",
                               {set_mac, clear_mac, initialized, busy, step_done, cmd_err, spike_ready},
                               source_address, fifo_level);
        end
        reset = 0;
    endtask

    task automatic test_random();
        logic [10:0] exp_stat, got_stat;
        do_reset();
        do_init();
        for (int c = 0; c < 600; c++) begin
            spike_valid = ($urandom_range(0, 99) < 55);
            spike_addr  = 12'($urandom_range(0, 12'hFFE));
            step_start  = ($urandom_range(0, 99) < ((m_phase == P_IDLE) ? 25 : 3));
            step_end    = ($urandom_range(0, 99) < ((m_phase == P_ACCUM) ? 20 : 3));
            init_req    = ($urandom_range(0, 99) < 2);
            cycle();
            exp_stat = {m_phase == P_INIT, m_phase == P_CLEAR, m_phase != P_IDLE, m_done, m_err,
                        m_ready, m_init, 4'(m_q.size())};
            got_stat = {set_mac, clear_mac, busy, step_done, cmd_err, spike_ready, initialized, fifo_level};
            checks++;
            if (got_stat !== exp_stat) begin
                errors++; $display("[TB] FAIL rand_status[%0d]: got %b expected %b", c, got_stat, exp_stat);
            end
            checks++;
            if (source_address !== m_src) begin
                errors++; $display("[TB] FAIL rand_src[%0d]: got %h expected %h", c, source_address, m_src);
            end
`ifdef MAC_SEQ_SPIKE_COUNT_EN
            checks++;
            if (step_spike_count !== 16'(m_cnt)) begin
                errors++; $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", c, step_spike_count, m_cnt);
            end
`endif
        end
        init_req = 0; step_start = 0; step_end = 0; spike_valid = 0;
    endtask

    initial begin
        reset = 1;
        init_req = 0; step_start = 0; step_end = 0; spike_valid = 0; spike_addr = '0;
        test_reset();
        test_init();
        test_cmd_err();
        test_accum_order();
        test_full_drain();
        test_clear_push();
`ifdef MAC_SEQ_SPIKE_COUNT_EN
        test_spike_count();
`endif
        test_reset_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
